pwm_dac_sink: RTL and testbench

// - Consumer end of the waveform sample stream. Accepts 8-bit samples over a valid/ready handshake.
// - Buffers them in a small FIFO and plays each one as one PWM period on a single pin (Pmod audio / RC-filter DAC).
// - Sits downstream of the waveform generators; pacing comes from back-pressure, not a shared sample-rate strobe.

---
 rtl/pwm_dac_pkg.sv | 16 +
 rtl/sample_fifo.sv | 58 +++++
 rtl/pwm_dac_sink.sv | 125 ++++++++++++
 tb/tb_pwm_dac_sink.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_pkg.sv
// Shared constants and helpers for the PWM DAC sample sink.
package pwm_dac_pkg;

    localparam int SAMPLE_W_DEF = 8;

    function automatic int midscale(input int w);
        return 2 ** (w - 1);
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int MIDSCALE = midscale(SAMPLE_W_DEF);

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and an occupancy count.
module sample_fifo
    import pwm_dac_pkg::*;
#(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int LW    = level_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_level <= r_level + 1'b1;
            end else if (i_pop && !i_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/pwm_dac_sink.sv
// PWM DAC sink: buffers streamed samples and plays one per PWM period.
// Optional mute input enabled by defining PWM_DAC_MUTE_EN.
module pwm_dac_sink
    import pwm_dac_pkg::*;
#(
    parameter int  SAMPLE_W   = SAMPLE_W_DEF,
    parameter int  DIV        = 1,
    parameter int  FIFO_DEPTH = 4,
    localparam int LW         = level_w(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef PWM_DAC_MUTE_EN
    input  logic                mute,
`endif
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                underrun_clr,
    output logic                pwm_out,
    output logic                underrun,
    output logic [LW-1:0]       fifo_level
);
    logic                r_ready_en;
    logic [SAMPLE_W-1:0] r_cnt;
    logic [SAMPLE_W-1:0] r_duty;
    logic                r_primed;
    logic                r_underrun;
    logic                r_pwm;

    logic                w_tick;
    logic                w_boundary;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [SAMPLE_W-1:0] w_head;
    logic                w_load_en;
    logic [SAMPLE_W-1:0] w_load_val;
    logic                w_underrun_set;

    generate
        if (DIV == 1) begin : g_no_prescale
            assign w_tick = 1'b1;
        end else begin : g_prescale
            localparam int PRE_W = $clog2(DIV);
            logic [PRE_W-1:0] r_pre;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pre <= '0;
                end else if (w_tick) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
            assign w_tick = (r_pre == PRE_W'(DIV - 1));
        end
    endgenerate

    assign w_boundary = w_tick && (r_cnt == '1);
    assign w_push     = s_valid && s_ready;
    // A push on a boundary cycle is not yet visible, so pop sees the old empty flag.
    assign w_pop      = w_boundary && !w_empty;

`ifdef PWM_DAC_MUTE_EN
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale(SAMPLE_W));
    assign w_load_en      = w_pop || (w_boundary && mute);
    assign w_load_val     = mute ? MID : w_head;
    assign w_underrun_set = w_boundary && w_empty && r_primed && !mute;
`else
    assign w_load_en      = w_pop;
    assign w_load_val     = w_head;
    assign w_underrun_set = w_boundary && w_empty && r_primed;
`endif

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (s_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_en <= 1'b0;
            r_cnt      <= '0;
            r_duty     <= '0;
            r_primed   <= 1'b0;
            r_underrun <= 1'b0;
            r_pwm      <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load_en) begin
                r_duty <= w_load_val;
            end
            if (w_pop) begin
                r_primed <= 1'b1;
            end
            // Set has priority over a simultaneous clear.
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
            r_pwm <= (r_cnt < r_duty);
        end
    end

    assign s_ready  = r_ready_en && !w_full;
    assign pwm_out  = r_pwm;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_pwm_dac_sink.sv
// Directed bench for pwm_dac_sink (DIV=1, FIFO_DEPTH=4); mute checks with PWM_DAC_MUTE_EN.
module tb_pwm_dac_sink;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       underrun_clr = 1'b0;
    logic       pwm_out;
    logic       underrun;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int n = 0;
    logic hist [0:2047];

    always #5 clk = ~clk;

    pwm_dac_sink #(.SAMPLE_W(8), .DIV(1), .FIFO_DEPTH(4)) u_dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PWM_DAC_MUTE_EN
        .mute         (1'b0),
`endif
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .underrun_clr (underrun_clr),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .fifo_level   (fifo_level)
    );

    // Cycle index since reset release: the boundary-loaded period is seen at n = 256*k+1 .. 256*k+256.
    always @(posedge clk) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    always @(negedge clk) begin
        if (n < 2048) hist[n] = pwm_out;
    end

`ifdef PWM_DAC_MUTE_EN
    logic       rst4 = 1'b1;
    logic       mute4 = 1'b1;
    logic       s_valid4 = 1'b0;
    logic       s_ready4;
    logic [7:0] s_data4 = 8'h00;
    logic       pwm_out4;
    logic       underrun4;
    logic [2:0] fifo_level4;
    int n4 = 0;

    pwm_dac_sink #(.SAMPLE_W(8), .DIV(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst4),
        .mute         (mute4),
        .s_valid      (s_valid4),
        .s_ready      (s_ready4),
        .s_data       (s_data4),
        .underrun_clr (1'b0),
        .pwm_out      (pwm_out4),
        .underrun     (underrun4),
        .fifo_level   (fifo_level4)
    );

    always @(posedge clk) begin
        if (rst4) n4 <= 0;
        else      n4 <= n4 + 1;
    end
`endif

    typedef struct {
        logic [7:0] data;
        int         exp_level;
        int         exp_highs;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_n(input int target);
        int guard = 0;
        while (n < target && guard < 5000) begin
            step();
            guard++;
        end
    endtask

    task automatic chk(input int act, input int exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic analyze(input int start, input int exp_h, input string name);
        int h = 0;
        int first = -1;
        int last = -1;
        for (int k = 0; k < 256; k++) begin
            if (hist[start + k] === 1'b1) begin
                h++;
                if (first < 0) first = k;
                last = k;
            end
        end
        chk(h, exp_h, {name, "_high_ticks"});
        chk(first, (exp_h > 0) ? 0 : -1, {name, "_first_high"});
        chk(last, exp_h - 1, {name, "_last_high"});
    endtask

    initial begin
        int acc_n;
        int g;

        vecs[0] = '{8'h00, 1, 0};
        vecs[1] = '{8'hFF, 2, 255};
        vecs[2] = '{8'h80, 3, 128};
        vecs[3] = '{8'h01, 4, 1};
        vecs[4] = '{8'h5A, 4, 90};

        // Reset state
        step();
        step();
        chk(pwm_out, 0, "rst_pwm_out");
        chk(underrun, 0, "rst_underrun");
        chk(fifo_level, 0, "rst_fifo_level");
        chk(s_ready, 0, "rst_s_ready");
        rst = 1'b0;
        step();
        chk(s_ready, 1, "ready_after_release");

        // Single sample 0x40, then starve
        s_valid = 1'b1;
        s_data  = 8'h40;
        step();
        s_valid = 1'b0;
        chk(fifo_level, 1, "duty_level_after_push");
        wait_n(256);
        chk(fifo_level, 0, "duty_level_after_pop");
        chk(underrun, 0, "duty_underrun_first_boundary");
        wait_n(511);
        chk(underrun, 0, "duty_underrun_before_second");
        wait_n(512);
        chk(underrun, 1, "duty_underrun_second_boundary");
        wait_n(770);
        analyze(257, 64, "duty40_p1");
        analyze(513, 64, "duty40_p2");

        // Underrun clear
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk(underrun, 0, "underrun_cleared");
        wait_n(1023);
        chk(underrun, 0, "underrun_stays_clear");
        wait_n(1024);
        chk(underrun, 1, "underrun_reasserted");

        // Mid-period reset with three queued samples
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 8'h11 * (i + 1);
            step();
        end
        s_valid = 1'b0;
        chk(fifo_level, 3, "queued_three");
        chk(pwm_out, 1, "pwm_high_before_reset");
        rst = 1'b1;
        step();
        chk(fifo_level, 0, "midrst_fifo_level");
        chk(pwm_out, 0, "midrst_pwm_out");
        chk(underrun, 0, "midrst_underrun");
        chk(s_ready, 0, "midrst_s_ready");
        step();
        rst = 1'b0;

        // Back-pressure and extremes, table driven
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = vecs[i].data;
            g = 0;
            while (!s_ready && g < 600) begin
                step();
                g++;
            end
            acc_n = n + 1;
            step();
            chk(fifo_level, vecs[i].exp_level, $sformatf("bp_level_push%0d", i));
            if (i == 3) chk(s_ready, 0, "bp_ready_drops_when_full");
            if (i == 4) chk(acc_n, 257, "bp_fifth_accept_cycle");
        end
        s_valid = 1'b0;
        wait_n(1281);
        chk(fifo_level, 0, "bp_drained");
        wait_n(1535);
        chk(underrun, 0, "bp_no_underrun_while_fed");
        wait_n(1536);
        chk(underrun, 1, "bp_underrun_when_empty");
        wait_n(1540);
        for (int i = 0; i < 5; i++) begin
            analyze(256 * (i + 1) + 1, vecs[i].exp_highs, $sformatf("bp_period%0d", i));
        end

`ifdef PWM_DAC_MUTE_EN
        begin
            int exp_lvl [3] = '{1, 0, 0};
            int highs;
            step();
            step();
            rst4 = 1'b0;
            s_valid4 = 1'b1;
            for (int i = 0; i < 2; i++) begin
                s_data4 = (i == 0) ? 8'hFF : 8'h10;
                g = 0;
                while (!s_ready4 && g < 100) begin
                    step();
                    g++;
                end
                step();
            end
            s_valid4 = 1'b0;
            for (int w = 1; w <= 3; w++) begin
                g = 0;
                while (n4 < 1024 * w && g < 5000) begin
                    step();
                    g++;
                end
                chk(fifo_level4, exp_lvl[w - 1], $sformatf("mute_level_w%0d", w));
                highs = 0;
                for (int k = 0; k < 1024; k++) begin
                    step();
                    if (pwm_out4 === 1'b1) highs++;
                end
                chk(highs, 512, $sformatf("mute_high_clks_w%0d", w));
            end
            chk(underrun4, 0, "mute_no_underrun");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
